// File: rtl/seq_gen_if.sv
// Frame request / serial stream bundle between a stimulus master and seq_gen.
// The master drives the request side; the generator drives status and the stream.
interface seq_gen_if #(
   parameter int DW = 8
) ();
   logic                  start;
   logic [DW-1:0]         din;
   logic [$clog2(DW):0]   len;
   logic                  ready;
   logic                  A;
   logic                  a_vld;
   logic                  done;
   logic                  busy;

   modport master (output start, din, len, input ready, A, a_vld, done, busy);
   modport slave  (input start, din, len, output ready, A, a_vld, done, busy);
endinterface

// File: rtl/seq_gen.sv
// Serial frame generator: captures a word on start and shifts len bits out on A,
// followed by GAP idle bit-times, feeding the sequence detectors.
module seq_gen #(
   parameter int DW        = 8,
   parameter int GAP       = 2,
   parameter int MSB_FIRST = 1
) (
   input logic      clk,
   input logic      rst_n,
   seq_gen_if.slave bus
);

   localparam int LW = $clog2(DW) + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam logic [LW-1:0] DW_L     = LW'(DW);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [DW-1:0] sh_r;
   logic [DW-1:0] sh_nxt_s;
   logic [LW-1:0] cnt_r;
   logic [LW-1:0] cnt_nxt_s;
   logic [GW-1:0] gcnt_r;
   logic [GW-1:0] gcnt_nxt_s;
   logic          a_r;
   logic          a_nxt_s;
   logic          vld_r;
   logic          vld_nxt_s;
   logic          done_r;
   logic          done_nxt_s;
   logic          ready_r;
   logic          busy_r;

   logic [LW-1:0] len_eff_s;
   logic [DW-1:0] aligned_s;
   logic [DW-1:0] load_s;
   logic          first_s;
   logic          nbit_s;
   logic [DW-1:0] sh_shift_s;
   logic          accept_s;

   assign accept_s = bus.start && (state_r == S_IDLE);

   // Load path: clamp len, left-align MSB-first payloads so the first bit sits at DW-1.
   always_comb begin
      if ((bus.len == {LW{1'b0}}) || (bus.len > DW_L)) begin
         len_eff_s = DW_L;
      end else begin
         len_eff_s = bus.len;
      end
      if (MSB_FIRST != 0) begin
         aligned_s  = bus.din << (DW_L - len_eff_s);
         first_s    = aligned_s[DW-1];
         load_s     = aligned_s << 1;
         nbit_s     = sh_r[DW-1];
         sh_shift_s = sh_r << 1;
      end else begin
         aligned_s  = bus.din;
         first_s    = bus.din[0];
         load_s     = bus.din >> 1;
         nbit_s     = sh_r[0];
         sh_shift_s = sh_r >> 1;
      end
   end

   // State register plus registered outputs and datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         sh_r    <= {DW{1'b0}};
         cnt_r   <= {LW{1'b0}};
         gcnt_r  <= {GW{1'b0}};
         a_r     <= 1'b0;
         vld_r   <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         sh_r    <= sh_nxt_s;
         cnt_r   <= cnt_nxt_s;
         gcnt_r  <= gcnt_nxt_s;
         a_r     <= a_nxt_s;
         vld_r   <= vld_nxt_s;
         done_r  <= done_nxt_s;
         ready_r <= (state_nxt_s == S_IDLE);
         busy_r  <= (state_nxt_s != S_IDLE);
      end
   end

   // Next-state logic; cnt_r holds the bits still to send after the one on A.
   always_comb begin
      state_nxt_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_nxt_s = S_SHIFT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (cnt_r != {LW{1'b0}}) begin
               state_nxt_s = S_SHIFT;
            end else if (GAP == 0) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_GAP;
            end
         end
         S_GAP: begin
            if (gcnt_r == {GW{1'b0}}) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_GAP;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, shifter and counters.
   always_comb begin
      a_nxt_s    = 1'b0;
      vld_nxt_s  = 1'b0;
      done_nxt_s = 1'b0;
      sh_nxt_s   = sh_r;
      cnt_nxt_s  = cnt_r;
      gcnt_nxt_s = gcnt_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               a_nxt_s   = first_s;
               vld_nxt_s = 1'b1;
               sh_nxt_s  = load_s;
               cnt_nxt_s = len_eff_s - LW'(1);
            end else begin
               sh_nxt_s  = sh_r;
            end
         end
         S_SHIFT: begin
            if (cnt_r != {LW{1'b0}}) begin
               a_nxt_s   = nbit_s;
               vld_nxt_s = 1'b1;
               sh_nxt_s  = sh_shift_s;
               cnt_nxt_s = cnt_r - LW'(1);
            end else begin
               done_nxt_s = 1'b1;
               sh_nxt_s   = {DW{1'b0}};
               gcnt_nxt_s = GAP_LAST;
            end
         end
         S_GAP: begin
            if (gcnt_r != {GW{1'b0}}) begin
               gcnt_nxt_s = gcnt_r - GW'(1);
            end else begin
               gcnt_nxt_s = {GW{1'b0}};
            end
         end
         default: begin
            sh_nxt_s   = {DW{1'b0}};
            cnt_nxt_s  = {LW{1'b0}};
            gcnt_nxt_s = {GW{1'b0}};
         end
      endcase
   end

   assign bus.A     = a_r;
   assign bus.a_vld = vld_r;
   assign bus.done  = done_r;
   assign bus.ready = ready_r;
   assign bus.busy  = busy_r;

endmodule
